// File: rtl/sd_cmd_sequencer.sv
// SD command transaction sequencer: latches a CPU command, launches the CMD engine,
// supervises the response timeout and keeps sticky completion/error status.
module sd_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_write,
    input  logic [5:0]   cmd_index_in,
    input  logic [1:0]   resp_type_in,
    input  logic         idx_chk_en_in,
    input  logic         crc_chk_en_in,
    input  logic [31:0]  cmd_arg_in,
    input  logic         timeout_en,
    input  logic         cmd_done,
    input  logic         resp_crc_ok,
    input  logic         resp_idx_ok,
    input  logic         resp_end_ok,
    input  logic [127:0] resp_in,
    input  logic [4:0]   status_clr,
    output logic         cmd_inhibit,
    output logic         cmd_start,
    output logic         cmd_abort,
    output logic [5:0]   cmd_index_out,
    output logic [31:0]  cmd_arg_out,
    output logic         resp_we,
    output logic [127:0] resp_out,
    output logic         cmd_complete,
    output logic [3:0]   err_status,
    output logic         err_irq,
    output logic         cmd_dropped
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RESP,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count;
    logic [1:0]    resp_type;
    logic          idx_chk_en, crc_chk_en;
    logic          crc_ok, idx_ok, end_ok;
    logic          timed_out;
    logic          accept, done_hit, term_hit;
    logic          cc_set;
    logic [3:0]    err_set;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cmd_done has priority over the terminal count in the same WAIT_RESP cycle.
    always_comb begin
        state_next  = state;
        cmd_start   = 1'b0;
        cmd_abort   = 1'b0;
        resp_we     = 1'b0;
        cc_set      = 1'b0;
        err_set     = 4'b0000;
        accept      = (state == S_IDLE) && cmd_write;
        done_hit    = (state == S_WAIT_RESP) && cmd_done;
        term_hit    = (state == S_WAIT_RESP) && timeout_en && (count == TERM) && !cmd_done;
        cmd_inhibit = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (cmd_write) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_start  = 1'b1;
                state_next = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (done_hit) begin
                    state_next = S_CHECK;
                end else if (term_hit) begin
                    err_set[3] = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_CHECK: begin
                cc_set = 1'b1;
                if (resp_type != 2'b00) begin
                    resp_we    = 1'b1;
                    err_set[2] = crc_chk_en & ~crc_ok;
                    err_set[1] = ~end_ok;
                    err_set[0] = idx_chk_en & ~idx_ok;
                end
                state_next = S_DONE;
            end
            S_DONE: begin
                cmd_abort  = timed_out;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign err_irq = |err_status;

    // Sticky status: a set in the same cycle as its W1C clear takes precedence.
    always_ff @(posedge clock) begin
        if (reset) begin
            count         <= '0;
            resp_type     <= 2'b00;
            idx_chk_en    <= 1'b0;
            crc_chk_en    <= 1'b0;
            cmd_index_out <= 6'd0;
            cmd_arg_out   <= 32'd0;
            crc_ok        <= 1'b0;
            idx_ok        <= 1'b0;
            end_ok        <= 1'b0;
            resp_out      <= 128'd0;
            timed_out     <= 1'b0;
            cmd_dropped   <= 1'b0;
            cmd_complete  <= 1'b0;
            err_status    <= 4'b0000;
        end else begin
            if (accept) begin
                cmd_index_out <= cmd_index_in;
                cmd_arg_out   <= cmd_arg_in;
                resp_type     <= resp_type_in;
                idx_chk_en    <= idx_chk_en_in;
                crc_chk_en    <= crc_chk_en_in;
                timed_out     <= 1'b0;
            end
            cmd_dropped <= cmd_write && (state != S_IDLE);
            if (state == S_ISSUE) begin
                count <= '0;
            end else if ((state == S_WAIT_RESP) && (count != TERM)) begin
                count <= count + 1'b1;
            end
            if (done_hit) begin
                crc_ok   <= resp_crc_ok;
                idx_ok   <= resp_idx_ok;
                end_ok   <= resp_end_ok;
                resp_out <= resp_in;
            end
            if (term_hit) timed_out <= 1'b1;
            cmd_complete <= (cmd_complete & ~status_clr[4]) | cc_set;
            err_status   <= (err_status & ~status_clr[3:0]) | err_set;
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: directed scenarios plus randomized
// transactions checked against a transaction-level model of the sticky status.
module tb_sd_cmd_sequencer;

    localparam int TMO = 64;

    logic         clock = 1'b0;
    logic         reset;
    logic         cmd_write;
    logic [5:0]   cmd_index_in;
    logic [1:0]   resp_type_in;
    logic         idx_chk_en_in, crc_chk_en_in;
    logic [31:0]  cmd_arg_in;
    logic         timeout_en;
    logic         cmd_done, resp_crc_ok, resp_idx_ok, resp_end_ok;
    logic [127:0] resp_in;
    logic [4:0]   status_clr;
    logic         cmd_inhibit, cmd_start, cmd_abort, resp_we;
    logic [5:0]   cmd_index_out;
    logic [31:0]  cmd_arg_out;
    logic [127:0] resp_out;
    logic         cmd_complete, err_irq, cmd_dropped;
    logic [3:0]   err_status;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the sticky status bits, tracked per transaction.
    logic       exp_cc;
    logic [3:0] exp_err;

    sd_cmd_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .cmd_write(cmd_write),
        .cmd_index_in(cmd_index_in), .resp_type_in(resp_type_in),
        .idx_chk_en_in(idx_chk_en_in), .crc_chk_en_in(crc_chk_en_in),
        .cmd_arg_in(cmd_arg_in), .timeout_en(timeout_en), .cmd_done(cmd_done),
        .resp_crc_ok(resp_crc_ok), .resp_idx_ok(resp_idx_ok), .resp_end_ok(resp_end_ok),
        .resp_in(resp_in), .status_clr(status_clr), .cmd_inhibit(cmd_inhibit),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort), .cmd_index_out(cmd_index_out),
        .cmd_arg_out(cmd_arg_out), .resp_we(resp_we), .resp_out(resp_out),
        .cmd_complete(cmd_complete), .err_status(err_status), .err_irq(err_irq),
        .cmd_dropped(cmd_dropped)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_inhibit"}, cmd_inhibit, 0);
        check_output({tag, "_start"}, cmd_start, 0);
        check_output({tag, "_abort"}, cmd_abort, 0);
        check_output({tag, "_index"}, cmd_index_out, 0);
        check_output({tag, "_arg"}, cmd_arg_out, 0);
        check_output({tag, "_resp_we"}, resp_we, 0);
        check_output({tag, "_resp_out"}, resp_out, 0);
        check_output({tag, "_cc"}, cmd_complete, 0);
        check_output({tag, "_err"}, err_status, 0);
        check_output({tag, "_irq"}, err_irq, 0);
        check_output({tag, "_dropped"}, cmd_dropped, 0);
    endtask

    // One command from IDLE; returns at the negedge of the first IDLE cycle after it.
    // dly < 0 means the engine never answers.
    task automatic apply_stimulus(input logic [5:0] idx, input logic [1:0] rt,
                                  input logic ie, input logic ce, input logic [31:0] arg,
                                  input logic te, input int dly, input logic c_ok,
                                  input logic i_ok, input logic e_ok, input logic [127:0] rsp,
                                  input logic drop, input logic clr_cc_in_check);
        int k;
        int outcome;
        logic [3:0] set_bits;
        cmd_write     = 1'b1;
        cmd_index_in  = idx;
        resp_type_in  = rt;
        idx_chk_en_in = ie;
        crc_chk_en_in = ce;
        cmd_arg_in    = arg;
        timeout_en    = te;
        @(negedge clock);
        cmd_write     = 1'b0;
        cmd_index_in  = 6'($urandom);
        cmd_arg_in    = $urandom;
        resp_type_in  = 2'($urandom);
        check_output("issue_start", cmd_start, 1);
        check_output("issue_inhibit", cmd_inhibit, 1);
        check_output("issue_index", cmd_index_out, idx);
        check_output("issue_arg", cmd_arg_out, arg);
        k = 0;
        outcome = 0;
        while (outcome == 0) begin
            @(negedge clock);
            cmd_write = 1'b0;
            check_output("wait_inhibit", cmd_inhibit, 1);
            if (k == 0) begin
                check_output("wait_start_low", cmd_start, 0);
                check_output("wait_no_drop", cmd_dropped, 0);
            end
            if (drop && k == 1) begin
                cmd_write  = 1'b1;
                cmd_arg_in = ~arg;
            end
            if (drop && k == 2) begin
                check_output("dropped_pulse", cmd_dropped, 1);
                check_output("dropped_arg_kept", cmd_arg_out, arg);
            end
            if (k == dly) begin
                cmd_done    = 1'b1;
                resp_crc_ok = c_ok;
                resp_idx_ok = i_ok;
                resp_end_ok = e_ok;
                resp_in     = rsp;
                outcome     = 1;
            end else if (te && k == TMO - 1) begin
                outcome = 2;
            end else if (k >= 400) begin
                n_checks++;
                n_fail++;
                $error("[TB] FAIL wait_bound observed=%0d expected=<400", k);
                outcome = 3;
            end
            k++;
        end
        if (outcome == 1) begin
            @(negedge clock);
            cmd_done = 1'b0;
            check_output("check_resp_we", resp_we, (rt != 2'b00));
            if (rt != 2'b00) check_output("check_resp_out", resp_out, rsp);
            check_output("check_cc_not_yet", cmd_complete, exp_cc);
            resp_in = ~rsp;
            if (clr_cc_in_check) status_clr = 5'b10000;
            set_bits = 4'b0000;
            if (rt != 2'b00) begin
                set_bits[2] = ce && !c_ok;
                set_bits[1] = !e_ok;
                set_bits[0] = ie && !i_ok;
            end
            exp_cc  = 1'b1;
            exp_err = exp_err | set_bits;
            @(negedge clock);
            status_clr = 5'b00000;
            check_output("done_cc", cmd_complete, exp_cc);
            check_output("done_err", err_status, exp_err);
            check_output("done_irq", err_irq, |exp_err);
            check_output("done_no_abort", cmd_abort, 0);
            check_output("done_inhibit", cmd_inhibit, 1);
            check_output("done_resp_we_low", resp_we, 0);
            @(negedge clock);
            check_output("idle_inhibit", cmd_inhibit, 0);
        end else if (outcome == 2) begin
            exp_err[3] = 1'b1;
            @(negedge clock);
            check_output("tmo_abort", cmd_abort, 1);
            check_output("tmo_err", err_status, exp_err);
            check_output("tmo_cc", cmd_complete, exp_cc);
            check_output("tmo_inhibit", cmd_inhibit, 1);
            @(negedge clock);
            check_output("tmo_idle_inhibit", cmd_inhibit, 0);
            check_output("tmo_abort_low", cmd_abort, 0);
        end
    endtask

    task automatic clear_status(input logic [4:0] clr);
        status_clr = clr;
        exp_cc  = exp_cc & ~clr[4];
        exp_err = exp_err & ~clr[3:0];
        @(negedge clock);
        status_clr = 5'b00000;
        check_output("clr_cc", cmd_complete, exp_cc);
        check_output("clr_err", err_status, exp_err);
    endtask

    initial begin
        logic [127:0] r;
        reset = 1'b1;
        cmd_write = 1'b0; cmd_index_in = 6'd0; resp_type_in = 2'b00;
        idx_chk_en_in = 1'b0; crc_chk_en_in = 1'b0; cmd_arg_in = 32'd0;
        timeout_en = 1'b0; cmd_done = 1'b0; resp_crc_ok = 1'b0; resp_idx_ok = 1'b0;
        resp_end_ok = 1'b0; resp_in = 128'd0; status_clr = 5'b00000;
        exp_cc = 1'b0; exp_err = 4'b0000;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_all_zero("reset");
        repeat (6) @(negedge clock);

        // R2 response, all checks passing
        r = {$urandom, $urandom, $urandom, $urandom};
        apply_stimulus(6'd2, 2'b01, 1'b0, 1'b0, 32'd0, 1'b1, 18, 1'b1, 1'b1, 1'b1, r, 1'b0, 1'b0);

        // No response at all: timeout
        apply_stimulus(6'd8, 2'b10, 1'b1, 1'b1, 32'h1234_5678, 1'b1, -1, 1'b1, 1'b1, 1'b1, r, 1'b0, 1'b0);
        check_output("tmo_only_bit", err_status, 4'b1000);
        clear_status(5'b11111);

        // CRC error only; index mismatch ignored because its check is off
        r = {$urandom, $urandom, $urandom, $urandom};
        apply_stimulus(6'd17, 2'b10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 5, 1'b0, 1'b0, 1'b1, r, 1'b0, 1'b0);
        check_output("crc_only_err", err_status, 4'b0100);
        check_output("crc_only_irq", err_irq, 1);
        clear_status(5'b11111);

        // Write while inhibited is dropped
        apply_stimulus(6'd7, 2'b10, 1'b1, 1'b1, 32'h0000_01AA, 1'b1, 10, 1'b1, 1'b1, 1'b1, r, 1'b1, 1'b0);

        // cmd_done on the terminal-count cycle wins over timeout
        apply_stimulus(6'd55, 2'b11, 1'b1, 1'b1, 32'hA5A5_0F0F, 1'b1, TMO - 1, 1'b1, 1'b1, 1'b1, r, 1'b0, 1'b0);
        check_output("done_wins_no_tmo", err_status[3], 0);

        // Clear of cmd_complete coinciding with its set
        apply_stimulus(6'd9, 2'b10, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b1, 3, 1'b1, 1'b1, 1'b1, r, 1'b0, 1'b1);

        // No-response command: bad flags ignored, no Response register write
        apply_stimulus(6'd0, 2'b00, 1'b1, 1'b1, 32'h1, 1'b0, 2, 1'b0, 1'b0, 1'b0, r, 1'b0, 1'b0);
        check_output("none_no_err", err_status, 4'b0000);

        // Reset in WAIT_RESP, then a stray cmd_done
        cmd_write = 1'b1; cmd_index_in = 6'd3; resp_type_in = 2'b10;
        cmd_arg_in = 32'hCAFE_0001; timeout_en = 1'b1;
        @(negedge clock);
        cmd_write = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_cc = 1'b0; exp_err = 4'b0000;
        check_all_zero("midreset");
        cmd_done = 1'b1; resp_crc_ok = 1'b0; resp_in = ~128'd0;
        @(negedge clock);
        cmd_done = 1'b0;
        check_all_zero("stray_done");
        @(negedge clock);
        check_all_zero("stray_done2");

        // Randomized transactions against the model
        for (int i = 0; i < 24; i++) begin
            logic [1:0] rt;
            logic te;
            int dly;
            rt  = 2'($urandom);
            te  = 1'($urandom);
            dly = $urandom_range(0, TMO + 12);
            r   = {$urandom, $urandom, $urandom, $urandom};
            apply_stimulus(6'($urandom), rt, 1'($urandom), 1'($urandom), $urandom, te, dly,
                           1'($urandom), 1'($urandom), 1'($urandom), r,
                           (dly >= 3) && ($urandom_range(0, 3) == 0), 1'($urandom));
            if ($urandom_range(0, 2) == 0) clear_status(5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
